// File: rtl/serdes_pkg.sv
// -----------------------------------------------------------------------------
// serdes_pkg
// Shared definitions for the serial deserializer slice.
//   state_t        : FSM encoding (IDLE, SHIFT, PAR; PAR used only when
//                    SERIAL_DESERIALIZER_PARITY_EN is defined)
//   DEFAULT_WIDTH  : default word length in bits
//   xor_reduce32   : reduction XOR helper for parity checking
// -----------------------------------------------------------------------------
package serdes_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2
  } state_t;

  // Reduction XOR over a zero-extended word; 0 means an even count of ones.
  function automatic logic xor_reduce32(input logic [31:0] i_data);
    return ^i_data;
  endfunction

endpackage

// File: rtl/bit_counter.sv
// -----------------------------------------------------------------------------
// bit_counter
// Counts accepted bits within a word (0..WIDTH-1).
//   clk      : clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   i_en     : increment enable
//   i_clr    : synchronous clear (has priority over i_en)
//   o_cnt    : current count
//   o_tc     : terminal count, high while o_cnt == WIDTH-1
// -----------------------------------------------------------------------------
module bit_counter #(
  parameter int WIDTH = 8,
  parameter int CW    = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
  input  logic          clk,
  input  logic          i_rst_n,
  input  logic          i_en,
  input  logic          i_clr,
  output logic [CW-1:0] o_cnt,
  output logic          o_tc
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] r_cnt;

  // Bit count register: clear wins over increment.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= {CW{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {CW{1'b0}};
    end else if (i_en) begin
      r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == LAST);

endmodule

// File: rtl/serial_deserializer.sv
// -----------------------------------------------------------------------------
// serial_deserializer
// Assembles WIDTH-bit words from a serial bit stream and presents them through
// a valid/ready holding register. Optional even-parity checking is enabled by
// defining the macro SERIAL_DESERIALIZER_PARITY_EN.
//   clk        : clock, rising edge
//   reset      : asynchronous active-low reset
//   bit_in     : serial data bit
//   bit_valid  : bit_in accepted on this edge
//   word_out   : assembled word, stable while word_valid=1
//   word_valid : word_out holds an unconsumed word
//   word_ready : consumer takes word_out when word_valid & word_ready
//   overrun    : one-cycle pulse, a completed word was dropped
//   parity_err : one-cycle pulse, parity mismatch (0 without the macro)
// Parameters: WIDTH (2..32), MSB_FIRST (1: first bit -> word_out[WIDTH-1]).
// -----------------------------------------------------------------------------
module serial_deserializer
  import serdes_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] w_sh_shift;
  logic [WIDTH-1:0] r_word_out;
  logic             r_word_valid;
  logic             r_overrun;
  logic [CW-1:0]    w_cnt;
  logic             w_tc;
  logic             w_shift_en;
  logic             w_cnt_clr;
  logic             w_word_done;
  logic [WIDTH-1:0] w_word_data;

  // Shift direction decides which end of the word the first bit reaches.
  generate
    if (MSB_FIRST) begin : g_msb
      assign w_sh_shift = {r_sh[WIDTH-2:0], bit_in};
    end else begin : g_lsb
      assign w_sh_shift = {bit_in, r_sh[WIDTH-1:1]};
    end
  endgenerate

  // Data bits are only shifted in while collecting the word, never in PAR.
  assign w_shift_en = bit_valid && ((r_state == ST_IDLE) || (r_state == ST_SHIFT));
  assign w_cnt_clr  = w_shift_en && (r_state == ST_SHIFT) && w_tc;

  bit_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_bit_counter (
    .clk     (clk),
    .i_rst_n (reset),
    .i_en    (w_shift_en),
    .i_clr   (w_cnt_clr),
    .o_cnt   (w_cnt),
    .o_tc    (w_tc)
  );

`ifdef SERIAL_DESERIALIZER_PARITY_EN
  logic w_par_bit;
  logic w_par_ok;
  logic r_par_err;

  // Parity bit arrives after the full data word sits in the shift register.
  assign w_par_bit   = bit_valid && (r_state == ST_PAR);
  assign w_par_ok    = (xor_reduce32(32'(r_sh)) ^ bit_in) == 1'b0;
  assign w_word_done = w_par_bit && w_par_ok;
  assign w_word_data = r_sh;

  // Parity error pulse register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_par_err <= 1'b0;
    end else begin
      r_par_err <= w_par_bit && !w_par_ok;
    end
  end

  assign parity_err = r_par_err;
`else
  // The completing bit is still on bit_in, so take the post-shift value.
  assign w_word_done = w_cnt_clr;
  assign w_word_data = w_sh_shift;
  assign parity_err  = 1'b0;
`endif

  // FSM next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_shift_en) begin
          w_state_nxt = ST_SHIFT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (w_cnt_clr) begin
`ifdef SERIAL_DESERIALIZER_PARITY_EN
          w_state_nxt = ST_PAR;
`else
          w_state_nxt = ST_IDLE;
`endif
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_PAR: begin
        if (bit_valid) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_PAR;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state and shift register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_sh    <= {WIDTH{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      if (w_shift_en) begin
        r_sh <= w_sh_shift;
      end
    end
  end

  // Holding register: a completed word loads if the slot is empty or is being
  // consumed on the same edge; otherwise the new word is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_word_out   <= {WIDTH{1'b0}};
      r_word_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_word_done) begin
        if (!r_word_valid || word_ready) begin
          r_word_out   <= w_word_data;
          r_word_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_word_valid && word_ready) begin
        r_word_valid <= 1'b0;
      end
    end
  end

  assign word_out   = r_word_out;
  assign word_valid = r_word_valid;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_serial_deserializer.sv
// -----------------------------------------------------------------------------
// tb_serial_deserializer
// Two instances share the stimulus: one MSB-first, one LSB-first (WIDTH=8).
// Bits are sent in time order from data[7] down to data[0].
// -----------------------------------------------------------------------------
module tb_serial_deserializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       bit_in;
  logic       bit_valid;
  logic       word_ready;
  logic [7:0] m_word, l_word;
  logic       m_valid, l_valid;
  logic       m_ovr, l_ovr;
  logic       m_perr, l_perr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .word_out(m_word), .word_valid(m_valid), .word_ready(word_ready),
    .overrun(m_ovr), .parity_err(m_perr)
  );

  serial_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .word_out(l_word), .word_valid(l_valid), .word_ready(word_ready),
    .overrun(l_ovr), .parity_err(l_perr)
  );

  typedef struct {
    logic [7:0] data;   // time-ordered bit stream, data[7] sent first
    logic [7:0] exp_m;  // expected word on the MSB-first instance
    logic [7:0] exp_l;  // expected word on the LSB-first instance
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Send the first nbits of d (starting at d[7]) on consecutive edges.
  task automatic send_bits(input logic [7:0] d, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      bit_in    = d[i];
      bit_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{8'hA5, 8'hA5, 8'hA5};
    vecs[1] = '{8'h80, 8'h80, 8'h01};
    vecs[2] = '{8'h3C, 8'h3C, 8'h3C};
    vecs[3] = '{8'hF0, 8'hF0, 8'h0F};
    vecs[4] = '{8'h12, 8'h12, 8'h48};
    vecs[5] = '{8'hC1, 8'hC1, 8'h83};
    vecs[6] = '{8'hFF, 8'hFF, 8'hFF};

    reset      = 1'b0;
    bit_in     = 1'b0;
    bit_valid  = 1'b0;
    word_ready = 1'b1;
    #1;
    chk("reset_word", {16'h0, m_word, l_word}, 32'h0);
    chk("reset_flags", {26'h0, m_valid, l_valid, m_ovr, l_ovr, m_perr, l_perr}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle_cycle();

`ifndef SERIAL_DESERIALIZER_PARITY_EN
    // Table: each word with word_ready=1, visible for exactly one cycle.
    for (int v = 0; v < 7; v++) begin
      send_bits(vecs[v].data, 7);
      chk("valid_before_last", {30'h0, m_valid, l_valid}, 32'h0);
      send_bits({vecs[v].data[0], 7'h0}, 1);
      chk("word_m", {24'h0, m_word}, {24'h0, vecs[v].exp_m});
      chk("word_l", {24'h0, l_word}, {24'h0, vecs[v].exp_l});
      chk("valid_set", {30'h0, m_valid, l_valid}, 32'h3);
      idle_cycle();
      chk("valid_one_cycle", {30'h0, m_valid, l_valid}, 32'h0);
    end

    // Overrun: two words with no consumer; held word stays A5.
    word_ready = 1'b0;
    send_bits(8'hA5, 8);
    chk("ovr_first_held", {23'h0, m_valid, m_word}, {23'h0, 1'b1, 8'hA5});
    send_bits(8'h3C, 7);
    chk("ovr_no_early_pulse", {30'h0, m_ovr, l_ovr}, 32'h0);
    send_bits(8'h3C, 8'h00 == 8'h00 ? 0 : 0);
    send_bits({1'b0, 7'h0}, 1);
    chk("ovr_pulse", {30'h0, m_ovr, l_ovr}, 32'h3);
    chk("ovr_word_kept", {15'h0, m_valid, m_word, l_word}, {15'h0, 1'b1, 8'hA5, 8'hA5});
    idle_cycle();
    chk("ovr_single_pulse", {30'h0, m_ovr, l_ovr}, 32'h0);
    word_ready = 1'b1;
    idle_cycle();
    chk("consume_clears", {30'h0, m_valid, l_valid}, 32'h0);

    // Simultaneous consume and completion: word replaced, valid held.
    word_ready = 1'b0;
    send_bits(8'hA5, 8);
    send_bits(8'h3C, 7);
    chk("swap_hold_a5", {23'h0, m_valid, m_word}, {23'h0, 1'b1, 8'hA5});
    word_ready = 1'b1;
    send_bits({1'b0, 7'h0}, 1);
    chk("swap_word", {23'h0, m_valid, m_word}, {23'h0, 1'b1, 8'h3C});
    chk("swap_no_ovr", {30'h0, m_ovr, l_ovr}, 32'h0);
    idle_cycle();
    chk("swap_consumed", {30'h0, m_valid, l_valid}, 32'h0);

    // Reset mid-word discards partial bits.
    send_bits(8'hFF, 5);
    reset = 1'b0;
    #1;
    chk("midreset_async", {22'h0, m_valid, l_valid, m_word}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle_cycle();
    send_bits(8'h5A, 8);
    chk("after_reset_word", {15'h0, m_valid, m_word, l_word}, {15'h0, 1'b1, 8'h5A, 8'h5A});
    idle_cycle();

    // Gaps in bit_valid hold state with no timeout.
    for (int i = 7; i >= 0; i--) begin
      send_bits({vecs[5].data[i], 7'h0}, 1);
      idle_cycle();
      idle_cycle();
      if (i == 1) begin
        chk("gap_no_early_valid", {31'h0, m_valid}, 32'h0);
      end
    end
    chk("gap_word_m", {24'h0, m_word}, {24'h0, 8'hC1});
    chk("gap_word_l", {24'h0, l_word}, {24'h0, 8'h83});
    chk("perr_tied_low", {30'h0, m_perr, l_perr}, 32'h0);
`else
    // Good parity: A5 has four ones, parity bit 0.
    send_bits(8'hA5, 8);
    chk("par_not_yet", {31'h0, m_valid}, 32'h0);
    send_bits(8'h00, 1);
    chk("par_good_word", {23'h0, m_valid, m_word}, {23'h0, 1'b1, 8'hA5});
    chk("par_good_noerr", {31'h0, m_perr}, 32'h0);
    idle_cycle();
    send_bits(8'hA5, 8);
    send_bits(8'h80, 1);
    chk("par_bad_err", {30'h0, m_perr, l_perr}, 32'h3);
    chk("par_bad_novalid", {30'h0, m_valid, l_valid}, 32'h0);
    idle_cycle();
    chk("par_err_pulse", {30'h0, m_perr, l_perr}, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_deserializer.md
SERIAL_DESERIALIZER -- requirements
Module: serial_deserializer

Interface
REQ-001 Parameter WIDTH, default 8, word length in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1; 1 means the first received bit lands in word_out[WIDTH-1], 0 means it lands in word_out[0].
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 bit_in  input  1  serial data bit, already registered upstream by a D flip-flop.
REQ-006 bit_valid  input  1  bit_in is accepted on any rising edge where bit_valid=1.
REQ-007 word_out  output  WIDTH  assembled word, held stable while word_valid=1.
REQ-008 word_valid  output  1  word_out holds an unconsumed word.
REQ-009 word_ready  input  1  consumer accepts word_out on any edge where word_valid=1 and word_ready=1.
REQ-010 overrun  output  1  one-cycle pulse; a completed word was dropped.
REQ-011 parity_err  output  1  one-cycle pulse on a parity mismatch; tied to 0 when parity is compiled out.

Function
REQ-012 Data path: shift register sh[WIDTH-1:0], bit counter cnt (0..WIDTH-1), output holding register, and an FSM with states IDLE, SHIFT and PAR (PAR exists only with the macro).
REQ-013 IDLE: cnt=0; an accepted bit SHALL be stored and move the FSM to SHIFT with cnt=1.
REQ-014 SHIFT: each accepted bit SHALL be stored and increment cnt; cycles with bit_valid=0 SHALL hold all state, with no timeout.
REQ-015 Word completion without the macro: accepting the bit at cnt=WIDTH-1 completes the word; FSM returns to IDLE with cnt=0.
REQ-016 Word completion with the macro: the same accept moves the FSM to PAR; the next accepted bit is the parity bit, and the FSM then returns to IDLE.
REQ-017 Latency: word_valid SHALL rise on the edge that accepts the final bit, so word_out is visible in the following cycle.
REQ-018 Accepting the final bit while the holding register is full and not being consumed SHALL drop the new word, keep the held word unchanged and pulse overrun.
REQ-019 Accepting the final bit on the same edge the held word is consumed (valid&ready) SHALL load the new word, keep word_valid=1 and raise no overrun.
REQ-020 A consume edge with no completing word SHALL clear word_valid on that edge.
REQ-021 Deserialization SHALL continue while word_valid=1; back-pressure never stalls bit acceptance.

Reset
REQ-022 reset=0 SHALL immediately force FSM=IDLE, cnt=0, sh=0, word_out=0, word_valid=0, overrun=0 and parity_err=0.
REQ-023 Reset asserted mid-word SHALL discard the partial word; the first bit accepted after release starts a new word.

Configuration
REQ-024 Macro SERIAL_DESERIALIZER_PARITY_EN: when defined, each word is followed by an even-parity bit, so the XOR of the WIDTH data bits and the parity bit equals 0.
REQ-025 With the macro, a good-parity word is delivered per REQ-017..019, with word_valid rising on the parity-bit edge.
REQ-026 With the macro, a bad-parity word SHALL be discarded and parity_err pulsed for one cycle; overrun is not evaluated for that word.
REQ-027 Without the macro: no PAR state, parity_err is a constant 0, and every WIDTH-th accepted bit completes a word.

Structure
REQ-028 Shared package serdes_pkg SHALL hold the FSM state typedef (IDLE, SHIFT, PAR) and the constant DEFAULT_WIDTH=8.
REQ-029 One sub-module, bit_counter, SHALL hold cnt with enable, synchronous clear and a terminal-count output; all other logic is in the top module.

Verification
REQ-030 Without the macro, WIDTH=8, MSB_FIRST=1, word_ready=1, bits 1,0,1,0,0,1,0,1 on consecutive cycles -> word_out=8'hA5 and word_valid=1 for exactly one cycle.
REQ-031 MSB_FIRST=0 with the same stream -> word_out=8'hA5, since the stream is a palindrome; then stream 1,0,0,0,0,0,0,0 -> word_out=8'h01.
REQ-032 word_ready=0, two full words sent (A5 then 3C) -> word_out stays A5, overrun pulses once at the final bit of 3C; then raising word_ready -> word_valid falls.
REQ-033 word_ready=1 exactly on the edge the second word completes -> word_out changes A5 to 3C with word_valid held at 1 and overrun=0.
REQ-034 reset pulsed low after 5 bits, then a full 8-bit stream for 8'h5A -> word_out=8'h5A, with no residue from the aborted word.
REQ-035 With the macro, 8'hA5 followed by parity 0 -> delivered; 8'hA5 followed by parity 1 -> parity_err pulses, word_valid stays 0.
